// File: rtl/shift_pload_sio.sv
// Full-duplex parallel-load shift engine: transmits a word on sout while capturing sin,
// advancing one bit per shift_en strobe, with a load/ready/done handshake.
module shift_pload_sio #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  input  logic             shift_en,
  input  logic             abort,
  input  logic             sin,
  output logic             sout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] din
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] tx, tx_nxt, tx_sh;
  logic [WIDTH-1:0] rx, rx_nxt, rx_sh;
  logic [WIDTH-1:0] din_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             done_nxt;
  logic             last_strobe;

  // The final strobe of a word frees the engine in the same cycle so a new word can chain with no gap.
  assign last_strobe = (state == SHIFT) && (cnt == CNT_LAST) && shift_en;
  assign ready       = (state == IDLE) || last_strobe;
  assign busy        = (state == SHIFT);
  assign sout        = (state == SHIFT) ? (MSB_FIRST ? tx[WIDTH-1] : tx[0]) : IDLE_LEVEL;

  always_comb begin
    if (MSB_FIRST) begin
      tx_sh = {tx[WIDTH-2:0], 1'b0};
      rx_sh = {rx[WIDTH-2:0], sin};
    end else begin
      tx_sh = {1'b0, tx[WIDTH-1:1]};
      rx_sh = {sin, rx[WIDTH-1:1]};
    end
  end

  // Abort outranks strobe and load; load is only honoured while ready.
  always_comb begin
    state_nxt = state;
    tx_nxt    = tx;
    rx_nxt    = rx;
    cnt_nxt   = cnt;
    din_nxt   = din;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          state_nxt = SHIFT;
          tx_nxt    = data;
          rx_nxt    = '0;
          cnt_nxt   = CNT_FULL;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (shift_en) begin
          tx_nxt  = tx_sh;
          rx_nxt  = rx_sh;
          cnt_nxt = cnt - CNT_LAST;
          if (cnt == CNT_LAST) begin
            din_nxt  = rx_sh;
            done_nxt = 1'b1;
            if (load) begin
              tx_nxt  = data;
              rx_nxt  = '0;
              cnt_nxt = CNT_FULL;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx   <= '0;
      rx   <= '0;
      cnt  <= '0;
      din  <= '0;
      done <= 1'b0;
    end else begin
      tx   <= tx_nxt;
      rx   <= rx_nxt;
      cnt  <= cnt_nxt;
      din  <= din_nxt;
      done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_shift_pload_sio.sv
// Self-checking bench for shift_pload_sio: three configurations driven in lockstep and
// compared every cycle against a bit-position reference model, plus directed corner cases.
module tb_shift_pload_sio;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [7:0] data = 8'h00;
  logic       shiftEn = 1'b0;
  logic       abort = 1'b0;
  logic       sin = 1'b0;

  logic       sout0, busy0, done0, ready0;
  logic       sout1, busy1, done1, ready1;
  logic       sout2, busy2, done2, ready2;
  logic [7:0] din0, din1;
  logic [4:0] din2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_pload_sio #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .load(load), .data(data), .ready(ready0),
    .shift_en(shiftEn), .abort(abort), .sin(sin), .sout(sout0), .busy(busy0),
    .done(done0), .din(din0));

  shift_pload_sio #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .load(load), .data(data), .ready(ready1),
    .shift_en(shiftEn), .abort(abort), .sin(sin), .sout(sout1), .busy(busy1),
    .done(done1), .din(din1));

  shift_pload_sio #(.WIDTH(5), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .load(load), .data(data[4:0]), .ready(ready2),
    .shift_en(shiftEn), .abort(abort), .sin(sin), .sout(sout2), .busy(busy2),
    .done(done2), .din(din2));

  logic        obsSout [3];
  logic        obsBusy [3];
  logic        obsDone [3];
  logic        obsReady [3];
  logic [31:0] obsDin [3];

  assign obsSout[0] = sout0;  assign obsBusy[0] = busy0;  assign obsDone[0] = done0;
  assign obsSout[1] = sout1;  assign obsBusy[1] = busy1;  assign obsDone[1] = done1;
  assign obsSout[2] = sout2;  assign obsBusy[2] = busy2;  assign obsDone[2] = done2;
  assign obsReady[0] = ready0; assign obsReady[1] = ready1; assign obsReady[2] = ready2;
  assign obsDin[0] = 32'(din0); assign obsDin[1] = 32'(din1); assign obsDin[2] = 32'(din2);

  // Reference model: a word in flight plus the count of bits already sent.
  int          cfgWidth [3] = '{8, 8, 5};
  logic        cfgMsb [3] = '{1'b1, 1'b0, 1'b1};
  logic        cfgIdle [3] = '{1'b1, 1'b0, 1'b0};
  logic        modelActive [3];
  logic [31:0] modelWord [3];
  logic [31:0] modelRx [3];
  logic [31:0] modelDin [3];
  logic        modelDone [3];
  int          modelSent [3];

  function automatic int bitPos(int i, int k);
    return cfgMsb[i] ? (cfgWidth[i] - 1 - k) : k;
  endfunction

  function automatic logic expSout(int i);
    if (!modelActive[i]) return cfgIdle[i];
    return modelWord[i][bitPos(i, modelSent[i])];
  endfunction

  function automatic logic expReady(int i);
    return !modelActive[i] || ((modelSent[i] == cfgWidth[i] - 1) && shiftEn);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      modelActive[i] = 1'b0;
      modelWord[i]   = '0;
      modelRx[i]     = '0;
      modelDin[i]    = '0;
      modelDone[i]   = 1'b0;
      modelSent[i]   = 0;
    end
  endtask

  task automatic modelEdge();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] mask;
      mask = (32'd1 << cfgWidth[i]) - 32'd1;
      modelDone[i] = 1'b0;
      if (!modelActive[i]) begin
        if (load) begin
          modelActive[i] = 1'b1;
          modelWord[i]   = 32'(data) & mask;
          modelRx[i]     = '0;
          modelSent[i]   = 0;
        end
      end else if (abort) begin
        modelActive[i] = 1'b0;
      end else if (shiftEn) begin
        modelRx[i][bitPos(i, modelSent[i])] = sin;
        modelSent[i]++;
        if (modelSent[i] == cfgWidth[i]) begin
          modelDin[i]  = modelRx[i];
          modelDone[i] = 1'b1;
          if (load) begin
            modelWord[i] = 32'(data) & mask;
            modelRx[i]   = '0;
            modelSent[i] = 0;
          end else begin
            modelActive[i] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkModel();
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("u%0d.sout", i), 32'(obsSout[i]), 32'(expSout(i)));
      checkOutput($sformatf("u%0d.busy", i), 32'(obsBusy[i]), 32'(modelActive[i]));
      checkOutput($sformatf("u%0d.done", i), 32'(obsDone[i]), 32'(modelDone[i]));
      checkOutput($sformatf("u%0d.ready", i), 32'(obsReady[i]), 32'(expReady(i)));
      checkOutput($sformatf("u%0d.din", i), obsDin[i], modelDin[i]);
    end
  endtask

  // Drive one cycle's inputs, let them settle, and compare against the model.
  task automatic applyStimulus(input logic l, input logic [7:0] d, input logic se,
                               input logic ab, input logic s);
    load = l; data = d; shiftEn = se; abort = ab; sin = s;
    #1;
    checkModel();
  endtask

  task automatic clockEdge();
    @(posedge clk);
    if (rst_n) modelEdge();
    else modelReset();
    #2;
  endtask

  typedef struct {
    logic       load;
    logic [7:0] data;
    logic       se;
    logic       sin;
    logic       expSout;
    logic       expBusy;
    logic       expDone;
    logic       expReady;
    logic [7:0] expDin;
  } vector_t;

  vector_t vec [11];

  initial begin
    logic [7:0]  patA5;
    logic [7:0]  pat81;
    logic [15:0] chain;
    int          doneCount;
    logic        busyDropped;

    // Full-duplex MSB first on u0: send 0xA5 while receiving 0x3C.
    vec[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
    vec[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vec[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vec[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vec[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vec[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vec[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vec[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vec[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
    vec[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C};
    vec[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C};

    modelReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("reset.sout0", 32'(sout0), 32'd1);
    checkOutput("reset.ready0", 32'(ready0), 32'd1);
    checkOutput("reset.din0", 32'(din0), 32'h00);
    clockEdge();
    rst_n = 1'b1;

    // Load with no strobes: the first bit appears immediately and holds.
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    clockEdge();
    for (int n = 0; n < 5; n++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checkOutput("hold.busy0", 32'(busy0), 32'd1);
      checkOutput("hold.sout0", 32'(sout0), 32'd1);
      checkOutput("hold.done0", 32'(done0), 32'd0);
      clockEdge();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    clockEdge();

    for (int v = 0; v < 11; v++) begin
      applyStimulus(vec[v].load, vec[v].data, vec[v].se, 1'b0, vec[v].sin);
      checkOutput($sformatf("vec%0d.sout0", v), 32'(sout0), 32'(vec[v].expSout));
      checkOutput($sformatf("vec%0d.busy0", v), 32'(busy0), 32'(vec[v].expBusy));
      checkOutput($sformatf("vec%0d.done0", v), 32'(done0), 32'(vec[v].expDone));
      checkOutput($sformatf("vec%0d.ready0", v), 32'(ready0), 32'(vec[v].expReady));
      checkOutput($sformatf("vec%0d.din0", v), 32'(din0), 32'(vec[v].expDin));
      clockEdge();
    end

    // LSB first on u1 with a strobe every third cycle, receiving 0x81.
    patA5 = 8'hA5;
    pat81 = 8'h81;
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    clockEdge();
    for (int b = 0; b < 8; b++) begin
      for (int c = 0; c < 3; c++) begin
        applyStimulus(1'b0, 8'h00, c == 2, 1'b0, pat81[b]);
        checkOutput($sformatf("lsb.bit%0d.sout1", b), 32'(sout1), 32'(patA5[b]));
        clockEdge();
      end
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("lsb.done1", 32'(done1), 32'd1);
    checkOutput("lsb.din1", 32'(din1), 32'h81);
    clockEdge();

    // Back-to-back chaining on u0: 0x0F then 0xF0 with no gap.
    chain = 16'h0FF0;
    doneCount = 0;
    busyDropped = 1'b0;
    applyStimulus(1'b1, 8'h0F, 1'b0, 1'b0, 1'b0);
    clockEdge();
    for (int n = 0; n < 16; n++) begin
      applyStimulus(n == 7, 8'hF0, 1'b1, 1'b0, n >= 8);
      checkOutput($sformatf("chain.bit%0d.sout0", n), 32'(sout0), 32'(chain[15-n]));
      if (!busy0) busyDropped = 1'b1;
      if (done0) doneCount++;
      clockEdge();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    if (done0) doneCount++;
    checkOutput("chain.doneCount", 32'(doneCount), 32'd2);
    checkOutput("chain.busyDropped", 32'(busyDropped), 32'd0);
    checkOutput("chain.din0", 32'(din0), 32'hFF);
    clockEdge();

    // Abort after three strobes with a simultaneous load.
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    clockEdge();
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      clockEdge();
    end
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
    clockEdge();
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    checkOutput("abort.busy0", 32'(busy0), 32'd0);
    checkOutput("abort.done0", 32'(done0), 32'd0);
    checkOutput("abort.din0", 32'(din0), 32'hFF);
    clockEdge();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("reload.busy0", 32'(busy0), 32'd1);
    checkOutput("reload.sout0", 32'(sout0), 32'd0);
    clockEdge();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    clockEdge();

    // Asynchronous reset between edges, four strobes into a transfer.
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    clockEdge();
    for (int n = 0; n < 4; n++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      clockEdge();
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("areset.sout0", 32'(sout0), 32'd1);
    checkOutput("areset.busy0", 32'(busy0), 32'd0);
    checkOutput("areset.done0", 32'(done0), 32'd0);
    checkOutput("areset.ready0", 32'(ready0), 32'd1);
    checkOutput("areset.din0", 32'(din0), 32'h00);
    checkModel();
    clockEdge();
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("areset.after.done0", 32'(done0), 32'd0);
    clockEdge();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(3) == 0, 8'($urandom), 1'($urandom_range(1)),
                    $urandom_range(31) == 0, 1'($urandom));
      clockEdge();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/shift_pload_sio.md
Name: shift_pload_sio

Overview:
- Parametrised full-duplex shift engine: parallel-load serial-out transmitter with simultaneous serial-in capture, a bit counter and a load/done handshake.
- Next generation of the 8-bit parallel-load serial-out shifter.
- Sits between the CPLD's byte-wide register interface and a serial link.
- Shifting is paced by an external shift strobe, so any bit-clock generator can drive it.

Parameters:
WIDTH, 8, word length in bits (2..32).
MSB_FIRST, 1, 1 = transmit/receive MSB first; 0 = LSB first.
IDLE_LEVEL, 0, value driven on sout while idle.

Ports:
clk  input  1  system clock, all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
load  input  1  request to start a transfer with data; accepted only when ready=1
data  input  WIDTH  word to transmit, sampled on the accepting edge
ready  output  1  block can accept load this cycle (combinational)
shift_en  input  1  one-cycle bit strobe; advances one bit per clk edge where high
abort  input  1  cancel current transfer
sin  input  1  serial input bit, sampled on shifting edges
sout  output  1  serial output bit
busy  output  1  transfer in progress
done  output  1  one-cycle pulse: word complete, din valid
din  output  WIDTH  last fully received word

Behaviour:
- Reset (rst_n low, immediate, asynchronous), all outputs:
  - state IDLE; tx and rx registers 0; counter 0.
  - sout=IDLE_LEVEL, busy=0, done=0, din=0, ready=1.
  - Reset mid-transfer discards the transfer with no done pulse.
- State IDLE:
  - ready=1, busy=0, sout=IDLE_LEVEL.
  - load=1 at an edge: tx<=data, rx<=0, cnt<=WIDTH, go to SHIFT.
- State SHIFT:
  - busy=1.
  - sout = tx[WIDTH-1] if MSB_FIRST else tx[0]. The first bit is valid in the cycle right after the load edge; there is no leading dummy bit.
  - Each edge with shift_en=1:
    - MSB_FIRST: tx<={tx[WIDTH-2:0],0}, rx<={rx[WIDTH-2:0],sin}.
    - LSB first: tx<={0,tx[WIDTH-1:1]}, rx<={sin,rx[WIDTH-1:1]}.
    - cnt<=cnt-1.
  - shift_en=0: hold all state.
- Completion (SHIFT, cnt==1, shift_en=1):
  - din<= final rx value including this edge's sin; done=1 for exactly the next cycle.
  - If load=1 on the same edge: new word accepted back-to-back and state stays SHIFT, with tx<=data, cnt<=WIDTH, rx<=0, and the first new bit on sout next cycle (zero-gap chaining).
  - Otherwise go to IDLE.
- ready = IDLE or (SHIFT and cnt==1 and shift_en). load while ready=0 is ignored; there is no queuing.
- abort=1 at an edge in SHIFT:
  - Go to IDLE, no done, din unchanged.
  - abort has priority over shift_en and load on the same edge.
  - abort in IDLE: no effect, and load on that edge is still accepted.
- Transfer latency: exactly WIDTH shift_en strobes from load to done. Edges without shift_en only stretch the transfer.
- Counter width is $clog2(WIDTH+1). No wrap: cnt never decrements below 1 in SHIFT.
- done never asserts together with a reset or abort edge.

Test Plan:
- Reset then idle, WIDTH=8, MSB_FIRST=1, IDLE_LEVEL=1 -> sout=1, ready=1, busy=0, din=0x00; load pulse with shift_en=0 for 5 cycles -> busy=1, sout holds 1 (bit7 of 0xA5), no done.
- Full-duplex MSB first: load 0xA5, shift_en every cycle, sin fed 0x3C MSB first -> sout sequence 1,0,1,0,0,1,0,1; done pulses on the cycle after the 8th strobe; din=0x3C; back to IDLE, sout=IDLE_LEVEL.
- LSB first (MSB_FIRST=0): load 0xA5, shift_en every 3rd cycle, sin fed 0x81 LSB first -> sout 1,0,1,0,0,1,0,1 (LSB first), each bit held 3 cycles; din=0x81 after 8 strobes.
- Back-to-back: load 0x0F, then 0xF0 asserted on the final-strobe edge -> 16 contiguous bits 00001111 11110000, done pulses twice, busy never drops.
- Abort: load 0xFF, abort after 3 strobes, with load=1 on the same edge -> IDLE, no done, din keeps previous value, load ignored; a new load on the next cycle is accepted.
- Async reset: assert rst_n low mid-clock after 4 strobes -> outputs return to reset values before the next edge, no done.
